// File: rtl/vga_scan_fetch.sv
// vga_scan_fetch: 640x480@60 VGA scan controller and pixel fetcher.
// Generates H/V timing from a divided pixel tick and walks a linear pixel
// address through image memory. It registers the returned grey byte onto
// R/G/B, aligned with sync and blank.
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   mem_addr[18:0]      linear pixel address to image memory
//   mem_rdata[31:0]     combinational read data; only [7:0] is used
//   vga_clk             pixel clock to DAC
//   vga_hsync/vsync     active-low syncs
//   vga_blank_n         1 while a visible pixel is presented
//   vga_r/g/b[7:0]      grey pixel byte replicated, 0 during blanking
//   frame_start         one-clk pulse when output pixel (0,0) appears
module vga_scan_fetch #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned H_VIS   = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_VIS   = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BP    = 33
) (
  input  logic        clk,
  input  logic        rst,
  output logic [18:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        vga_clk,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_blank_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_start
);

  localparam int unsigned H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned H_W    = $clog2(H_TOT);
  localparam int unsigned V_W    = $clog2(V_TOT);
  localparam int unsigned ADDR_W = 19;
  localparam int unsigned PIX_W  = 8;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(CLK_DIV / 2);
  localparam logic [H_W-1:0]   H_LAST     = H_W'(H_TOT - 1);
  localparam logic [H_W-1:0]   H_VIS_END  = H_W'(H_VIS);
  localparam logic [H_W-1:0]   H_VIS_LAST = H_W'(H_VIS - 1);
  localparam logic [H_W-1:0]   H_SYNC_BEG = H_W'(H_VIS + H_FP);
  localparam logic [H_W-1:0]   H_SYNC_END = H_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [V_W-1:0]   V_LAST     = V_W'(V_TOT - 1);
  localparam logic [V_W-1:0]   V_VIS_END  = V_W'(V_VIS);
  localparam logic [V_W-1:0]   V_VIS_LAST = V_W'(V_VIS - 1);
  localparam logic [V_W-1:0]   V_SYNC_BEG = V_W'(V_VIS + V_FP);
  localparam logic [V_W-1:0]   V_SYNC_END = V_W'(V_VIS + V_FP + V_SYNC);

  logic [DIV_W-1:0] divCnt;
  logic [DIV_W-1:0] divNext;
  logic [H_W-1:0]   hCnt;
  logic [V_W-1:0]   vCnt;
  logic             tick;
  logic             hWrap;
  logic             vWrap;
  logic             visible;
  logic             lastPixel;
  logic             frameOrigin;
  logic             hSyncActive;
  logic             vSyncActive;
  logic             vgaClkNext;
  logic [PIX_W-1:0] pixel;
  logic [23:0]      unusedRdata;

  // Only the low byte carries the grey level.
  assign pixel       = mem_rdata[PIX_W-1:0];
  assign unusedRdata = mem_rdata[31:8];

  // Decode of the current scan position.
  always_comb begin
    tick        = (divCnt == DIV_LAST);
    divNext     = tick ? '0 : divCnt + DIV_W'(1);
    hWrap       = (hCnt == H_LAST);
    vWrap       = (vCnt == V_LAST);
    visible     = (hCnt < H_VIS_END) && (vCnt < V_VIS_END);
    lastPixel   = (hCnt == H_VIS_LAST) && (vCnt == V_VIS_LAST);
    frameOrigin = (hCnt == '0) && (vCnt == '0);
    hSyncActive = (hCnt >= H_SYNC_BEG) && (hCnt < H_SYNC_END);
    vSyncActive = (vCnt >= V_SYNC_BEG) && (vCnt < V_SYNC_END);
    // With no division there is no half period to shape, so the clock is held low.
    vgaClkNext  = (CLK_DIV > 1) && (divNext >= DIV_HALF);
  end

  // Pixel-tick divider and the registered pixel clock derived from it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divCnt  <= '0;
      vga_clk <= 1'b0;
    end else begin
      divCnt  <= divNext;
      vga_clk <= vgaClkNext;
    end
  end

  // Horizontal and vertical scan counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hCnt <= '0;
      vCnt <= '0;
    end else if (tick) begin
      if (hWrap) begin
        hCnt <= '0;
        vCnt <= vWrap ? '0 : vCnt + V_W'(1);
      end else begin
        hCnt <= hCnt + H_W'(1);
      end
    end
  end

  // Incremental address: step across visible pixels, park on the last pixel
  // through blanking, and return to 0 as the scan wraps to (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr <= '0;
    end else if (tick) begin
      if (hWrap && vWrap) begin
        mem_addr <= '0;
      end else if (visible && !lastPixel) begin
        mem_addr <= mem_addr + ADDR_W'(1);
      end
    end
  end

  // Output stage: pixel, blank and syncs share one tick of latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_blank_n <= 1'b0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && frameOrigin;
      if (tick) begin
        vga_r       <= visible ? pixel : '0;
        vga_g       <= visible ? pixel : '0;
        vga_b       <= visible ? pixel : '0;
        vga_blank_n <= visible;
        vga_hsync   <= ~hSyncActive;
        vga_vsync   <= ~vSyncActive;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_fetch.sv
// tb_vga_scan_fetch: directed bench for vga_scan_fetch.
// dutA uses the real 640x480 timing with CLK_DIV=2 and covers reset and line timing.
// dutB uses a shrunken raster with CLK_DIV=1 so that whole frames, the address
// boundary and a mid-frame reset fit in a short run.
module tb_vga_scan_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- dutA: full timing, CLK_DIV=2 ----------------
  logic        rstA;
  logic [18:0] addrA;
  logic [31:0] rdataA;
  logic        vclkA, hsA, vsA, blankA, fsA;
  logic [7:0]  rA, gA, bA;
  logic        phaseA;

  // phaseA tracks the pixel-tick phase. Off-tick cycles present a corrupted byte,
  // so any sampling between ticks shows up on R/G/B.
  always @(posedge clk or posedge rstA)
    if (rstA) phaseA <= 1'b0;
    else      phaseA <= ~phaseA;

  assign rdataA = {24'hA5C35A, phaseA ? addrA[7:0] : ~addrA[7:0]};

  vga_scan_fetch #(.CLK_DIV(2)) dutA (
    .clk(clk), .rst(rstA), .mem_addr(addrA), .mem_rdata(rdataA),
    .vga_clk(vclkA), .vga_hsync(hsA), .vga_vsync(vsA), .vga_blank_n(blankA),
    .vga_r(rA), .vga_g(gA), .vga_b(bA), .frame_start(fsA)
  );

  // ---------------- dutB: 8x6 visible, 15x10 total, CLK_DIV=1 ----------------
  logic        rstB;
  logic [18:0] addrB;
  logic [31:0] rdataB;
  logic        vclkB, hsB, vsB, blankB, fsB;
  logic [7:0]  rB, gB, bB;

  assign rdataB = {24'h5AA5C3, addrB[7:0]};

  vga_scan_fetch #(
    .CLK_DIV(1), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dutB (
    .clk(clk), .rst(rstB), .mem_addr(addrB), .mem_rdata(rdataB),
    .vga_clk(vclkB), .vga_hsync(hsB), .vga_vsync(vsB), .vga_blank_n(blankB),
    .vga_r(rB), .vga_g(gB), .vga_b(bB), .frame_start(fsB)
  );

  // Reset values on both DUTs, then release dutA and check the first clk.
  task automatic test_reset();
    checks++; if ({blankA, hsA, vsA, fsA, vclkA} !== 5'b01100) begin failures++;
      $display("FAIL resetA.ctl got=%b exp=01100", {blankA, hsA, vsA, fsA, vclkA}); end
    checks++; if ({rA, gA, bA} !== 24'd0) begin failures++;
      $display("FAIL resetA.rgb got=%h exp=000000", {rA, gA, bA}); end
    checks++; if (addrA !== 19'd0) begin failures++;
      $display("FAIL resetA.addr got=%0d exp=0", addrA); end
    checks++; if ({blankB, hsB, vsB, fsB, vclkB, rB, gB, bB, addrB} !== {5'b01100, 24'd0, 19'd0}) begin
      failures++; $display("FAIL resetB.all got=%h", {blankB, hsB, vsB, fsB, vclkB, rB, gB, bB, addrB}); end
    rstA = 1'b0;
    @(negedge clk); // k=1: divider has not ticked yet
    checks++; if ({blankA, hsA, vsA, fsA} !== 4'b0110) begin failures++;
      $display("FAIL firstclkA.ctl got=%b exp=0110", {blankA, hsA, vsA, fsA}); end
    checks++; if (addrA !== 19'd0) begin failures++;
      $display("FAIL firstclkA.addr got=%0d exp=0", addrA); end
    checks++; if (vclkA !== 1'b1) begin failures++;
      $display("FAIL firstclkA.vclk got=%b exp=1", vclkA); end
  endtask

  // Two full lines of dutA at real timing; continues directly from test_reset (k=2..).
  task automatic test_line_timing();
    int p, h, v, q, hq, vq;
    int firstBlank = -1, firstHsLow = -1, hsLowClks = 0, blankClks = 0;
    logic        expBlank, expHs, expFs, expClk;
    logic [7:0]  expR;
    logic [18:0] expAddr;
    for (int k = 2; k <= 3210; k++) begin
      @(negedge clk);
      p = k / 2 - 1; h = p % 800; v = p / 800;
      expBlank = (h < 640) && (v < 480);
      expR     = expBlank ? 8'((v * 640 + h) & 255) : 8'd0;
      expHs    = !(h >= 656 && h < 752);
      expFs    = (k == 2);
      expClk   = (k % 2 == 1);
      q = k / 2; hq = q % 800; vq = q / 800;
      expAddr  = (hq < 640) ? 19'(vq * 640 + hq) : 19'((vq + 1) * 640);
      checks++; if (blankA !== expBlank) begin failures++;
        $display("FAIL lineA.blank k=%0d got=%b exp=%b", k, blankA, expBlank); end
      checks++; if ({rA, gA, bA} !== {expR, expR, expR}) begin failures++;
        $display("FAIL lineA.rgb k=%0d got=%h exp=%h", k, {rA, gA, bA}, {expR, expR, expR}); end
      checks++; if ({hsA, vsA} !== {expHs, 1'b1}) begin failures++;
        $display("FAIL lineA.sync k=%0d got=%b exp=%b", k, {hsA, vsA}, {expHs, 1'b1}); end
      checks++; if (fsA !== expFs) begin failures++;
        $display("FAIL lineA.fs k=%0d got=%b exp=%b", k, fsA, expFs); end
      checks++; if (vclkA !== expClk) begin failures++;
        $display("FAIL lineA.vclk k=%0d got=%b exp=%b", k, vclkA, expClk); end
      checks++; if (addrA !== expAddr) begin failures++;
        $display("FAIL lineA.addr k=%0d got=%0d exp=%0d", k, addrA, expAddr); end
      if (k <= 3200) begin
        if (blankA === 1'b1) begin blankClks++; if (firstBlank < 0) firstBlank = k; end
        if (hsA === 1'b0) begin hsLowClks++; if (firstHsLow < 0) firstHsLow = k; end
      end
    end
    checks++; if (firstHsLow - firstBlank !== 1312) begin failures++;
      $display("FAIL lineA.hs_offset got=%0d exp=1312", firstHsLow - firstBlank); end
    checks++; if (hsLowClks !== 384) begin failures++;
      $display("FAIL lineA.hs_width got=%0d exp=384", hsLowClks); end
    checks++; if (blankClks !== 2560) begin failures++;
      $display("FAIL lineA.visible got=%0d exp=2560", blankClks); end
  endtask

  // Per-clk check of dutB from a reset release; clk k shows pixel k-1 of the raster.
  task automatic scan_check_b(input int ncyc, output int fsCnt, output int blankCnt,
                              output int vsLowCnt, output int hsLowCnt, output int maxAddr);
    int p, h, v, q, hq, vq;
    logic        expBlank, expHs, expVs, expFs;
    logic [7:0]  expR;
    logic [18:0] expAddr;
    fsCnt = 0; blankCnt = 0; vsLowCnt = 0; hsLowCnt = 0; maxAddr = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      p = (k - 1) % 150; h = p % 15; v = p / 15;
      expBlank = (h < 8) && (v < 6);
      expR     = expBlank ? 8'((v * 8 + h) & 255) : 8'd0;
      expHs    = !(h >= 10 && h < 13);
      expVs    = !(v >= 7 && v < 9);
      expFs    = (p == 0);
      q = k % 150; hq = q % 15; vq = q / 15;
      expAddr  = (hq < 8 && vq < 6) ? 19'(vq * 8 + hq) : (vq < 5 ? 19'((vq + 1) * 8) : 19'd47);
      checks++; if ({blankB, hsB, vsB, fsB, vclkB} !== {expBlank, expHs, expVs, expFs, 1'b0}) begin
        failures++; $display("FAIL scanB.ctl k=%0d got=%b exp=%b", k,
          {blankB, hsB, vsB, fsB, vclkB}, {expBlank, expHs, expVs, expFs, 1'b0}); end
      checks++; if ({rB, gB, bB} !== {expR, expR, expR}) begin failures++;
        $display("FAIL scanB.rgb k=%0d got=%h exp=%h", k, {rB, gB, bB}, {expR, expR, expR}); end
      checks++; if (addrB !== expAddr) begin failures++;
        $display("FAIL scanB.addr k=%0d got=%0d exp=%0d", k, addrB, expAddr); end
      if (fsB === 1'b1) fsCnt++;
      if (int'(addrB) > maxAddr) maxAddr = int'(addrB);
      if (k <= 150) begin
        if (blankB === 1'b1) blankCnt++;
        if (vsB === 1'b0) vsLowCnt++;
        if (hsB === 1'b0) hsLowCnt++;
      end
    end
  endtask

  // Two-plus frames at CLK_DIV=1: frame period, visible count, sync widths, address ceiling.
  task automatic test_small_frame();
    int fsCnt, blankCnt, vsLowCnt, hsLowCnt, maxAddr;
    @(negedge clk);
    rstB = 1'b0;
    scan_check_b(310, fsCnt, blankCnt, vsLowCnt, hsLowCnt, maxAddr);
    checks++; if (fsCnt !== 3) begin failures++;
      $display("FAIL frameB.fs_count got=%0d exp=3", fsCnt); end
    checks++; if (blankCnt !== 48) begin failures++;
      $display("FAIL frameB.visible got=%0d exp=48", blankCnt); end
    checks++; if (vsLowCnt !== 30) begin failures++;
      $display("FAIL frameB.vs_width got=%0d exp=30", vsLowCnt); end
    checks++; if (hsLowCnt !== 30) begin failures++;
      $display("FAIL frameB.hs_width got=%0d exp=30", hsLowCnt); end
    checks++; if (maxAddr !== 47) begin failures++;
      $display("FAIL frameB.max_addr got=%0d exp=47", maxAddr); end
  endtask

  // One-clk reset at line 3, pixel 5: outputs clear at once, then a clean restart from (0,0).
  task automatic test_reset_midframe();
    int fsCnt, blankCnt, vsLowCnt, hsLowCnt, maxAddr;
    @(negedge clk);
    rstB = 1'b1;
    @(negedge clk);
    rstB = 1'b0;
    repeat (50) @(negedge clk);
    checks++; if (blankB !== 1'b1 || addrB !== 19'd29) begin failures++;
      $display("FAIL midB.pre got=%b/%0d exp=1/29", blankB, addrB); end
    rstB = 1'b1;
    #1;
    checks++; if ({blankB, hsB, vsB, fsB, vclkB, rB, gB, bB, addrB} !== {5'b01100, 24'd0, 19'd0}) begin
      failures++; $display("FAIL midB.async got=%h", {blankB, hsB, vsB, fsB, vclkB, rB, gB, bB, addrB}); end
    @(negedge clk);
    rstB = 1'b0;
    scan_check_b(160, fsCnt, blankCnt, vsLowCnt, hsLowCnt, maxAddr);
    checks++; if (fsCnt !== 2) begin failures++;
      $display("FAIL midB.fs_count got=%0d exp=2", fsCnt); end
    checks++; if (blankCnt !== 48) begin failures++;
      $display("FAIL midB.visible got=%0d exp=48", blankCnt); end
  endtask

  initial begin
    rstA = 1'b1;
    rstB = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_line_timing();
    test_small_frame();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
